// File: rtl/emb_seq_ctrl.sv
// ---------------------------------------------------------------------------
// emb_seq_ctrl
//   Sequencer for emb_block. Latches a string of CHAR_NUM characters, runs one
//   embedding lookup per character through the emb_run/emb_valid level
//   protocol and streams each EMB_DIM*N_LEN vector downstream with a
//   valid/ready handshake. When every vector has been accepted it raises
//   'valid' and holds it until 'run' drops.
//
//   Optional feature macro: EMB_SEQ_SKIP_PAD_EN
//     When defined, characters equal to PAD_CHAR skip the lookup and are
//     emitted as an all-zero vector after a single cycle.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   run          level: high = process string, low = abort / return to idle
//   d            input string, char i at d[i*CHAR_LEN +: CHAR_LEN]
//   valid        high while the whole string has been delivered (DONE)
//   emb_run      to emb_block.run
//   emb_d        to emb_block.d (character code to look up)
//   emb_valid    from emb_block.valid
//   emb_q        from emb_block.q (embedding vector)
//   o_valid      output vector available
//   o_ready      downstream accepts when o_valid & o_ready
//   o_idx        character index of o_data
//   o_data       embedding vector
// ---------------------------------------------------------------------------
module emb_seq_ctrl #(
  parameter int                  CHAR_NUM = 8,
  parameter int                  CHAR_LEN = 8,
  parameter int                  EMB_DIM  = 24,
  parameter int                  N_LEN    = 16,
  parameter logic [CHAR_LEN-1:0] PAD_CHAR = '0,
  localparam int                 IDX_W    = (CHAR_NUM > 1) ? $clog2(CHAR_NUM) : 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [CHAR_NUM*CHAR_LEN-1:0] d,
  output logic                         valid,
  output logic                         emb_run,
  output logic [CHAR_LEN-1:0]          emb_d,
  input  logic                         emb_valid,
  input  logic [EMB_DIM*N_LEN-1:0]     emb_q,
  output logic                         o_valid,
  input  logic                         o_ready,
  output logic [IDX_W-1:0]             o_idx,
  output logic [EMB_DIM*N_LEN-1:0]     o_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FETCH,
    S_OUT,
    S_DONE
  } state_t;

  state_t                         r_state;
  state_t                         w_next_state;
  logic [CHAR_NUM*CHAR_LEN-1:0]   r_buf;
  logic [IDX_W-1:0]               r_idx;
  logic [IDX_W-1:0]               r_oidx;
  logic [EMB_DIM*N_LEN-1:0]       r_data;

  logic [CHAR_LEN-1:0]            w_chars [CHAR_NUM];
  logic [IDX_W-1:0]               w_idx_inc;
  logic                           w_last;
  logic [CHAR_LEN-1:0]            w_cur_char;
  logic [CHAR_LEN-1:0]            w_next_char;

  // Datapath strobes decoded by the FSM.
  logic                           w_latch;    // IDLE->LOAD: capture d, idx=0
  logic                           w_capture;  // FETCH done: take emb_q
  logic                           w_advance;  // OUT accepted, more chars: idx++
  logic                           w_pad;      // pad char: emit zero vector

  always_comb begin
    for (int i = 0; i < CHAR_NUM; i++) begin
      w_chars[i] = r_buf[i*CHAR_LEN +: CHAR_LEN];
    end
  end

  assign w_idx_inc   = r_idx + 1'b1;
  assign w_last      = (r_idx == IDX_W'(CHAR_NUM - 1));
  assign w_cur_char  = w_chars[r_idx];
  assign w_next_char = w_chars[w_idx_inc];

`ifndef EMB_SEQ_SKIP_PAD_EN
  // PAD_CHAR only matters when pad skipping is built in.
  logic w_unused_pad;
  assign w_unused_pad = ^PAD_CHAR;
`endif

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and strobe decode. Dropping run aborts from any state.
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    w_latch      = 1'b0;
    w_capture    = 1'b0;
    w_advance    = 1'b0;
    w_pad        = 1'b0;

    if (!run) begin
      w_next_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_next_state = S_LOAD;
          w_latch      = 1'b1;
        end
        S_LOAD: begin
`ifdef EMB_SEQ_SKIP_PAD_EN
          if (w_cur_char == PAD_CHAR) begin
            w_next_state = S_OUT;
            w_pad        = 1'b1;
          end else begin
            w_next_state = S_FETCH;
          end
`else
          w_next_state = S_FETCH;
`endif
        end
        S_FETCH: begin
          // Fetch time is whatever emb_block takes; only emb_valid matters.
          if (emb_valid) begin
            w_next_state = S_OUT;
            w_capture    = 1'b1;
          end
        end
        S_OUT: begin
          if (o_ready) begin
            if (w_last) begin
              w_next_state = S_DONE;
            end else begin
              w_advance = 1'b1;
              // OUT already held emb_run low for a cycle with the next char
              // on emb_d, so emb_block is primed and LOAD can be skipped.
`ifdef EMB_SEQ_SKIP_PAD_EN
              if (w_next_char == PAD_CHAR) begin
                w_next_state = S_OUT;
                w_pad        = 1'b1;
              end else begin
                w_next_state = S_FETCH;
              end
`else
              w_next_state = S_FETCH;
`endif
            end
          end
        end
        S_DONE: begin
          w_next_state = S_DONE;
        end
        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Datapath: character buffer, index and output vector
  // -------------------------------------------------------------------------
  // NOTE: the character buffer is reset along with the other registers; it is
  // a small flop bank (not a RAM), so the reset costs nothing structural and
  // keeps emb_d at zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf  <= '0;
      r_idx  <= '0;
      r_oidx <= '0;
      r_data <= '0;
    end else begin
      if (w_latch) begin
        r_buf <= d;
        r_idx <= '0;
      end
      if (w_advance) begin
        r_idx <= w_idx_inc;
      end
      if (w_capture) begin
        r_data <= emb_q;
        r_oidx <= r_idx;
      end
      if (w_pad) begin
        // From LOAD the pad is the current char; from OUT it is the next one.
        r_data <= '0;
        r_oidx <= (r_state == S_LOAD) ? r_idx : w_idx_inc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (Moore, decoded from state)
  // -------------------------------------------------------------------------
  assign valid   = (r_state == S_DONE);
  assign emb_run = (r_state == S_FETCH);
  assign o_valid = (r_state == S_OUT);
  assign o_idx   = r_oidx;
  assign o_data  = r_data;

  always_comb begin
    emb_d = '0;
    case (r_state)
      S_LOAD, S_FETCH: emb_d = w_cur_char;
      // Preload the following lookup while the current vector waits.
      S_OUT:           emb_d = w_last ? '0 : w_next_char;
      default:         emb_d = '0;
    endcase
  end

endmodule

// File: tb/tb_emb_seq_ctrl.sv
`timescale 1ns/1ps
module tb_emb_seq_ctrl;

  localparam int CHAR_NUM  = 8;
  localparam int CHAR_LEN  = 8;
  localparam int EMB_DIM   = 24;
  localparam int N_LEN     = 16;
  localparam int IDX_W     = $clog2(CHAR_NUM);
  localparam int VW        = EMB_DIM * N_LEN;
  localparam int DW        = CHAR_NUM * CHAR_LEN;
  localparam int FETCH_LAT = EMB_DIM + 1;
  localparam int BUDGET    = 2000;
  localparam logic [CHAR_LEN-1:0] PAD = 8'd0;
  localparam logic [VW-1:0] GARBAGE = {(VW/8){8'hA5}};
`ifdef EMB_SEQ_SKIP_PAD_EN
  localparam int EXP_RISES_PAD = CHAR_NUM - 1;
`else
  localparam int EXP_RISES_PAD = CHAR_NUM;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic [DW-1:0]     d = '0;
  logic              valid;
  logic              emb_run;
  logic [CHAR_LEN-1:0] emb_d;
  logic              emb_valid;
  logic [VW-1:0]     emb_q;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [IDX_W-1:0]  o_idx;
  logic [VW-1:0]     o_data;
  logic              spur = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [VW-1:0]    data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  emb_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .d         (d),
    .valid     (valid),
    .emb_run   (emb_run),
    .emb_d     (emb_d),
    .emb_valid (emb_valid),
    .emb_q     (emb_q),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .o_idx     (o_idx),
    .o_data    (o_data)
  );

  // ---------------- emb_block stand-in: ROM + level protocol ----------------
  function automatic logic [N_LEN-1:0] rom_word(input int a);
    logic [31:0] t;
    t = 32'(a) * 32'h9E37_79B9 + 32'h0000_1234;
    return t[31:16] ^ t[15:0];
  endfunction

  function automatic logic [VW-1:0] rom_vec(input logic [CHAR_LEN-1:0] c);
    logic [VW-1:0] v;
    v = '0;
    for (int e = 0; e < EMB_DIM; e++) v[e*N_LEN +: N_LEN] = rom_word(int'(c) * EMB_DIM + e);
    return v;
  endfunction

  logic [CHAR_LEN-1:0] m_addr;
  int                  m_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_addr <= '0;
    end else if (!emb_run) begin
      m_cnt  <= 0;
      m_addr <= emb_d;
    end else if (m_cnt < FETCH_LAT) begin
      m_cnt <= m_cnt + 1;
    end
  end
  wire m_hit = emb_run && (m_cnt == FETCH_LAT);
  assign emb_valid = m_hit || spur;
  assign emb_q     = m_hit ? rom_vec(m_addr) : GARBAGE;

  // ---------------- scoreboard ----------------
  function automatic logic [VW-1:0] exp_vec(input logic [CHAR_LEN-1:0] c);
`ifdef EMB_SEQ_SKIP_PAD_EN
    if (c == PAD) return '0;
`endif
    return rom_vec(c);
  endfunction

  task automatic push_string(input logic [DW-1:0] s);
    exp_t e;
    for (int i = 0; i < CHAR_NUM; i++) begin
      e.idx  = IDX_W'(i);
      e.data = exp_vec(s[i*CHAR_LEN +: CHAR_LEN]);
      sb.push_back(e);
    end
  endtask

  function automatic exp_t sb_pop();
    exp_t e;
    e.idx  = 'x;
    e.data = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    return e;
  endfunction

  function automatic logic [DW-1:0] rand_string(input int lo);
    logic [DW-1:0] s;
    s = '0;
    for (int i = 0; i < CHAR_NUM; i++) s[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'($urandom_range(255, lo));
    return s;
  endfunction

  task automatic settle();
    @(negedge clk);
    run = 1'b0; o_ready = 1'b0; spur = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [DW-1:0] dv;
    int cyc;
    #1;
    n_tests++;
    if ({valid, emb_run, o_valid} !== 3'b000 || emb_d !== '0 || o_idx !== '0 || o_data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: valid/emb_run/o_valid=%b emb_d=%h o_idx=%0d, required all 0",
               {valid, emb_run, o_valid}, emb_d, o_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    dv = rand_string(1);
    @(negedge clk); d = dv; run = 1'b1; o_ready = 1'b1;
    cyc = 0;
    while (!emb_run && cyc < BUDGET) begin @(negedge clk); cyc++; end
    n_tests++;
    if (emb_run !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_wait: emb_run=%b, required 1", emb_run); end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({valid, emb_run, o_valid} !== 3'b000 || emb_d !== '0 || o_idx !== '0 || o_data !== '0) begin
      n_fail++;
      $display("FAIL reset_async: valid/emb_run/o_valid=%b emb_d=%h o_idx=%0d, required all 0",
               {valid, emb_run, o_valid}, emb_d, o_idx);
    end
    @(negedge clk); run = 1'b0; rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({valid, emb_run, o_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_idle: valid/emb_run/o_valid=%b, required 000", {valid, emb_run, o_valid});
    end
    run = 1'b1;
    @(negedge clk);
    n_tests++;
    if (emb_run !== 1'b0 || emb_d !== dv[CHAR_LEN-1:0]) begin
      n_fail++; $display("FAIL reset_load: emb_run=%b emb_d=%h, required 0 and %h", emb_run, emb_d, dv[CHAR_LEN-1:0]);
    end
    @(negedge clk);
    n_tests++;
    if (emb_run !== 1'b1) begin n_fail++; $display("FAIL reset_fetch: emb_run=%b, required 1", emb_run); end
    settle();
  endtask

  task automatic test_basic();
    logic [DW-1:0] dv;
    exp_t e;
    int beats, cyc;
    dv = '0;
    for (int i = 0; i < CHAR_NUM; i++) dv[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(i);
    push_string(dv);
    @(negedge clk); d = dv; run = 1'b1; o_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < CHAR_NUM && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL basic_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
      end
    end
    n_tests++;
    if (beats != CHAR_NUM) begin n_fail++; $display("FAIL basic_count: %0d beats, required %0d", beats, CHAR_NUM); end
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_done: valid=%b o_valid=%b, required 1/0", valid, o_valid);
    end
    repeat (4) @(negedge clk);
    n_tests++;
    if (valid !== 1'b1 || emb_run !== 1'b0) begin
      n_fail++; $display("FAIL basic_hold: valid=%b emb_run=%b, required 1/0", valid, emb_run);
    end
    run = 1'b0;
    @(negedge clk);
    n_tests++;
    if (valid !== 1'b0) begin n_fail++; $display("FAIL basic_release: valid=%b, required 0", valid); end
    settle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] dv;
    logic [VW-1:0] held;
    exp_t e;
    int beats, cyc;
    bit stalled, chk_fetch, stable;
    dv = rand_string(1);
    push_string(dv);
    @(negedge clk); d = dv; run = 1'b1; o_ready = 1'b1;
    beats = 0; cyc = 0; stalled = 0; chk_fetch = 0;
    while (beats < CHAR_NUM && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (chk_fetch) begin
        chk_fetch = 0; n_tests++;
        if (emb_run !== 1'b1 || o_valid !== 1'b0) begin
          n_fail++; $display("FAIL bp_resume: emb_run=%b o_valid=%b, required 1/0", emb_run, o_valid);
        end
      end
      if (o_valid && o_idx == IDX_W'(3) && !stalled) begin
        stalled = 1; o_ready = 1'b0; spur = 1'b1; held = o_data; stable = 1;
        repeat (10) begin
          @(negedge clk); cyc++;
          if (o_valid !== 1'b1 || o_idx !== IDX_W'(3) || o_data !== held || emb_run !== 1'b0) stable = 0;
        end
        n_tests++;
        if (!stable) begin
          n_fail++; $display("FAIL bp_stall: o_valid=%b o_idx=%0d emb_run=%b data_held=%b, required 1/3/0/1",
                             o_valid, o_idx, emb_run, o_data === held);
        end
        spur = 1'b0; o_ready = 1'b1;
      end
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL bp_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
        if (o_idx == IDX_W'(3)) chk_fetch = 1;
      end
    end
    n_tests++;
    if (beats != CHAR_NUM || !stalled) begin
      n_fail++; $display("FAIL bp_count: %0d beats stalled=%0d, required %0d and 1", beats, stalled, CHAR_NUM);
    end
    settle();
  endtask

  task automatic test_abort();
    logic [DW-1:0] d1, d2;
    exp_t e;
    int beats, cyc;
    bit seen;
    d1 = rand_string(1);
    push_string(d1);
    @(negedge clk); d = d1; run = 1'b1; o_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 2 && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL abort_pre_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
      end
    end
    cyc = 0;
    while (!emb_run && cyc < BUDGET) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    n_tests++;
    if (emb_run !== 1'b1) begin n_fail++; $display("FAIL abort_in_fetch: emb_run=%b, required 1", emb_run); end
    run = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({valid, emb_run, o_valid} !== 3'b000) begin
      n_fail++; $display("FAIL abort_idle: valid/emb_run/o_valid=%b, required 000", {valid, emb_run, o_valid});
    end
    seen = 0;
    repeat (EMB_DIM + 4) begin @(negedge clk); if (o_valid) seen = 1; end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL abort_quiet: o_valid seen=1, required 0"); end
    sb.delete();
    d2 = rand_string(1);
    push_string(d2);
    d = d2; run = 1'b1;
    beats = 0; cyc = 0;
    while (beats < CHAR_NUM && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL abort_restart_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
      end
    end
    n_tests++;
    if (beats != CHAR_NUM) begin n_fail++; $display("FAIL abort_restart_count: %0d beats, required %0d", beats, CHAR_NUM); end
    settle();
  endtask

  task automatic test_d_change();
    logic [DW-1:0] dv;
    exp_t e;
    int beats, cyc;
    dv = rand_string(1);
    push_string(dv);
    @(negedge clk); d = dv; run = 1'b1; o_ready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < CHAR_NUM && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      d = {$urandom(), $urandom()};
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL dchg_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
      end
    end
    n_tests++;
    if (beats != CHAR_NUM) begin n_fail++; $display("FAIL dchg_count: %0d beats, required %0d", beats, CHAR_NUM); end
    settle();
  endtask

  task automatic test_pad_char();
    logic [DW-1:0] dv;
    exp_t e;
    int beats, cyc, rises;
    logic prev;
    dv = rand_string(1);
    dv[5*CHAR_LEN +: CHAR_LEN] = PAD;
    push_string(dv);
    @(negedge clk); d = dv; run = 1'b1; o_ready = 1'b1;
    beats = 0; cyc = 0; rises = 0; prev = 1'b0;
    while (beats < CHAR_NUM && cyc < BUDGET) begin
      @(negedge clk); cyc++;
      if (emb_run && !prev) rises++;
      prev = emb_run;
      if (o_valid && o_ready) begin
        e = sb_pop(); n_tests++; beats++;
        if (o_idx !== e.idx || o_data !== e.data) begin
          n_fail++; $display("FAIL pad_beat: idx %0d data %h, required idx %0d data %h", o_idx, o_data, e.idx, e.data);
        end
      end
    end
    n_tests++;
    if (beats != CHAR_NUM || rises != EXP_RISES_PAD) begin
      n_fail++; $display("FAIL pad_lookups: %0d beats %0d emb_run pulses, required %0d and %0d",
                         beats, rises, CHAR_NUM, EXP_RISES_PAD);
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_d_change();
    test_pad_char();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
